// File: rtl/rv_core_pkg.sv
// rv_core_pkg: types and constants shared by the instruction fetch path.
//   inst_t      32-bit instruction word
//   addr_t      32-bit byte address
//   INST_NOP    canonical NOP (addi x0,x0,0) returned for bad fetches
//   inst_rsp_t  one fetch response {data, pc, err}
//   pc_bad()    true when a byte address is misaligned or past a ROM of 'depth' words
package rv_core_pkg;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] addr_t;

  localparam inst_t INST_NOP = 32'h0000_0013;

  typedef struct packed {
    inst_t data;
    addr_t pc;
    logic  err;
  } inst_rsp_t;

  // Compare in 34 bits so 4*depth cannot overflow the address width.
  function automatic logic pc_bad(input addr_t pc, input int unsigned depth);
    return (pc[1:0] != 2'b00) || ({2'b00, pc} >= (34'(depth) * 34'd4));
  endfunction

endpackage

// File: rtl/inst_rsp_fifo.sv
// inst_rsp_fifo: DEPTH-entry in-order response buffer with flush.
//   clk, rst_n    clock, synchronous active-low reset (clears pointers/count)
//   flush_i       drop every buffered entry; empty on the next cycle
//   push_i        write push_data_i at the tail (caller guarantees not full)
//   pop_i         retire the head entry (caller guarantees not empty)
//   head_o        oldest entry; meaningful only while count_o != 0
//   count_o       number of buffered entries, 0..DEPTH
module inst_rsp_fifo
  import rv_core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  inst_rsp_t     push_data_i,
  input  logic          pop_i,
  output inst_rsp_t     head_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  inst_rsp_t     mem_q [DEPTH];
  inst_rsp_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Explicit wrap so non-power-of-two depths stay correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_rom_rsp.sv
// inst_rom_rsp: instruction ROM with a valid/ready fetch request port and an
// ordered, flushable response buffer.
//   clk, rst_n              clock, synchronous active-low reset
//   pc_i, pc_send_valid_i   fetch request (byte address)
//   pc_receive_ready_o      request can be accepted this cycle
//   inst_data_o/pc_o/err_o  response word, its request pc, bad-address flag
//   inst_valid_o            response available
//   inst_ready_i            fetch unit takes the response
//   flush_i                 discard every outstanding response
// Optional (macro INST_ROM_WR_EN): wr_en_i, wr_addr_i, wr_data_i write port.
// Without the macro INST_ROM has no writer in this file; its contents are
// preloaded into INST_ROM by the enclosing environment.
//
// The ROM read is sampled at the accepting edge straight into the response
// buffer, so a request is never "in flight" past its accept edge: occupancy is
// simply the buffer count, and a response is visible the cycle after accept.
module inst_rom_rsp
  import rv_core_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 4096,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  addr_t pc_i,
  input  logic  pc_send_valid_i,
  output logic  pc_receive_ready_o,
  output inst_t inst_data_o,
  output addr_t inst_pc_o,
  output logic  inst_err_o,
  output logic  inst_valid_o,
  input  logic  inst_ready_i,
  input  logic  flush_i
`ifdef INST_ROM_WR_EN
  ,
  input  logic  wr_en_i,
  input  addr_t wr_addr_i,
  input  inst_t wr_data_i
`endif
);

  localparam int unsigned AW = $clog2(ROM_DEPTH);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  inst_t INST_ROM [ROM_DEPTH];

  logic [AW-1:0] rd_idx;
  logic          rd_bad;
  logic          accept;
  logic          pop;
  logic          out_vld;
  inst_rsp_t     push_rsp;
  inst_rsp_t     head_rsp;
  logic [CW-1:0] count;

  assign rd_idx = pc_i[AW+1:2];
  assign rd_bad = pc_bad(pc_i, ROM_DEPTH);

  // Readiness uses only registered occupancy: a pop in the same cycle does
  // not reopen a full buffer, keeping inst_ready_i off the request path.
  assign pc_receive_ready_o = rst_n && (count < CW'(RSP_DEPTH)) && !flush_i;
  assign accept             = pc_send_valid_i && pc_receive_ready_o;

  // Combinational view of the array is captured at the accept edge; a write
  // to the same word at that edge lands after the sample (old data wins).
  always_comb begin
    push_rsp.data = rd_bad ? INST_NOP : INST_ROM[rd_idx];
    push_rsp.pc   = pc_i;
    push_rsp.err  = rd_bad;
  end

`ifdef INST_ROM_WR_EN
  always_ff @(posedge clk) begin
    if (wr_en_i && !pc_bad(wr_addr_i, ROM_DEPTH))
      INST_ROM[wr_addr_i[AW+1:2]] <= wr_data_i;
  end
`endif

  inst_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .push_i     (accept),
    .push_data_i(push_rsp),
    .pop_i      (pop),
    .head_o     (head_rsp),
    .count_o    (count)
  );

  // Gate with rst_n so every output reads zero while reset is asserted,
  // even before the first reset edge has cleared the buffer.
  assign out_vld = rst_n && (count != '0);
  assign pop     = out_vld && inst_ready_i;

  assign inst_valid_o = out_vld;
  assign inst_data_o  = out_vld ? head_rsp.data : '0;
  assign inst_pc_o    = out_vld ? head_rsp.pc   : '0;
  assign inst_err_o   = out_vld ? head_rsp.err  : 1'b0;

endmodule

// File: tb/tb_inst_rom_rsp.sv
// Bench for inst_rom_rsp: directed cycle table (ordering, back-pressure,
// bad addresses, flush, reset) then randomized traffic against a queue model.
module tb_inst_rom_rsp;
  import rv_core_pkg::*;

  localparam int unsigned ROM_D = 4096;
  localparam int unsigned RSP_D = 2;

  logic  clk = 1'b0;
  logic  rst_n;
  addr_t pc;
  logic  pc_vld;
  logic  pc_rdy;
  inst_t data;
  addr_t rpc;
  logic  err;
  logic  vld;
  logic  rdy;
  logic  flush;
`ifdef INST_ROM_WR_EN
  logic  wr_en   = 1'b0;
  addr_t wr_addr = '0;
  inst_t wr_data = '0;
`endif

  always #5 clk = ~clk;

  inst_rom_rsp #(.ROM_DEPTH(ROM_D), .RSP_DEPTH(RSP_D)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_i              (pc),
    .pc_send_valid_i   (pc_vld),
    .pc_receive_ready_o(pc_rdy),
    .inst_data_o       (data),
    .inst_pc_o         (rpc),
    .inst_err_o        (err),
    .inst_valid_o      (vld),
    .inst_ready_i      (rdy),
    .flush_i           (flush)
`ifdef INST_ROM_WR_EN
    ,
    .wr_en_i           (wr_en),
    .wr_addr_i         (wr_addr),
    .wr_data_i         (wr_data)
`endif
  );

  typedef struct {
    logic  rst;
    logic  req;
    addr_t pc;
    logic  rdy;
    logic  fl;
    logic  e_rdy;
    logic  e_vld;
    inst_t e_data;
    addr_t e_pc;
    logic  e_err;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  inst_t rom_m [ROM_D];
  inst_rsp_t q[$];

  function automatic vec_t mk(logic r, logic rq, addr_t p, logic rd, logic f,
                              logic er, logic ev, inst_t ed, addr_t ep, logic ee);
    vec_t v;
    v.rst = r; v.req = rq; v.pc = p; v.rdy = rd; v.fl = f;
    v.e_rdy = er; v.e_vld = ev; v.e_data = ed; v.e_pc = ep; v.e_err = ee;
    return v;
  endfunction

  function automatic inst_rsp_t ref_rsp(addr_t p);
    inst_rsp_t r;
    r.pc   = p;
    r.err  = (p % 4 != 0) || (p >= 32'(4 * ROM_D));
    r.data = r.err ? INST_NOP : rom_m[p / 4];
    return r;
  endfunction

  task automatic chk(input string nm, input string tag, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s[%0d]: got %h expected %h", nm, tag, idx, act, exp);
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are compared at the
  // following falling edge, then one rising edge commits the cycle.
  task automatic run(input vec_t v, input string tag, input int idx);
    rst_n  = v.rst;
    pc_vld = v.req;
    pc     = v.pc;
    rdy    = v.rdy;
    flush  = v.fl;
    @(negedge clk);
    chk("ready", tag, idx, 32'(pc_rdy), 32'(v.e_rdy));
    chk("valid", tag, idx, 32'(vld),    32'(v.e_vld));
    chk("data",  tag, idx, data,        v.e_data);
    chk("pc",    tag, idx, rpc,         v.e_pc);
    chk("err",   tag, idx, 32'(err),    32'(v.e_err));
    @(posedge clk);
    #1;
  endtask

  localparam inst_t R0 = 32'h0050_0093, R1 = 32'h00A0_0113,
                    R2 = 32'h0020_81B3, R3 = 32'h0000_0013,
                    RL = 32'h1234_5678;

  initial begin
    vec_t tbl[$];
    vec_t v;
    inst_rsp_t h;

    for (int i = 0; i < int'(ROM_D); i++) rom_m[i] = $urandom;
    rom_m[0] = R0; rom_m[1] = R1; rom_m[2] = R2; rom_m[3] = R3;
    rom_m[ROM_D-1] = RL;
    for (int i = 0; i < int'(ROM_D); i++) dut.INST_ROM[i] = rom_m[i];

    //             rst req pc        rdy fl | rdy vld data pc        err
    // reset, request ignored
    tbl.push_back(mk(0, 0, 0,        0, 0,   0, 0, 0,  0,        0));
    tbl.push_back(mk(0, 1, 0,        1, 0,   0, 0, 0,  0,        0));
    // back-to-back 0,4,8,12 with ready held
    tbl.push_back(mk(1, 1, 32'h0,    1, 0,   1, 0, 0,  0,        0));
    tbl.push_back(mk(1, 1, 32'h4,    1, 0,   1, 1, R0, 32'h0,    0));
    tbl.push_back(mk(1, 1, 32'h8,    1, 0,   1, 1, R1, 32'h4,    0));
    tbl.push_back(mk(1, 1, 32'hC,    1, 0,   1, 1, R2, 32'h8,    0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 1, R3, 32'hC,    0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 0, 0,  0,        0));
    // back-pressure: full after 2, head held, then drains in order
    tbl.push_back(mk(1, 1, 32'h0,    0, 0,   1, 0, 0,  0,        0));
    tbl.push_back(mk(1, 1, 32'h4,    0, 0,   1, 1, R0, 32'h0,    0));
    tbl.push_back(mk(1, 1, 32'h8,    0, 0,   0, 1, R0, 32'h0,    0));
    tbl.push_back(mk(1, 1, 32'h8,    0, 0,   0, 1, R0, 32'h0,    0));
    tbl.push_back(mk(1, 1, 32'h8,    1, 0,   0, 1, R0, 32'h0,    0));
    tbl.push_back(mk(1, 1, 32'h8,    0, 0,   1, 1, R1, 32'h4,    0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   0, 1, R1, 32'h4,    0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 1, R2, 32'h8,    0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 0, 0,  0,        0));
    // misaligned, first out-of-range, last in-range word
    tbl.push_back(mk(1, 1, 32'h6,    1, 0,   1, 0, 0,  0,        0));
    tbl.push_back(mk(1, 1, 32'h4000, 1, 0,   1, 1, R3, 32'h6,    1));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 1, R3, 32'h4000, 1));
    tbl.push_back(mk(1, 1, 32'h3FFC, 1, 0,   1, 0, 0,  0,        0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 1, RL, 32'h3FFC, 0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 0, 0,  0,        0));
    // flush with a full buffer and a concurrent request
    tbl.push_back(mk(1, 1, 32'h0,    0, 0,   1, 0, 0,  0,        0));
    tbl.push_back(mk(1, 1, 32'h4,    0, 0,   1, 1, R0, 32'h0,    0));
    tbl.push_back(mk(1, 1, 32'hC,    0, 1,   0, 1, R0, 32'h0,    0));
    tbl.push_back(mk(1, 1, 32'h8,    1, 0,   1, 0, 0,  0,        0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 1, R2, 32'h8,    0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 0, 0,  0,        0));
    // one-cycle reset mid-stream
    tbl.push_back(mk(1, 1, 32'h0,    0, 0,   1, 0, 0,  0,        0));
    tbl.push_back(mk(1, 1, 32'h4,    0, 0,   1, 1, R0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 32'h8,    0, 0,   0, 0, 0,  0,        0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 0, 0,  0,        0));
    tbl.push_back(mk(1, 1, 32'hC,    1, 0,   1, 0, 0,  0,        0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 1, R3, 32'hC,    0));
    tbl.push_back(mk(1, 0, 0,        1, 0,   1, 0, 0,  0,        0));

    foreach (tbl[i]) run(tbl[i], "tbl", i);

`ifdef INST_ROM_WR_EN
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hDEAD_BEEF;
    run(mk(1, 0, 0,     1, 0, 1, 0, 0,            0,     0), "wr", 0);
    wr_en = 1'b0;
    run(mk(1, 1, 32'h10, 1, 0, 1, 0, 0,           0,     0), "wr", 1);
    run(mk(1, 0, 0,     1, 0, 1, 1, 32'hDEAD_BEEF, 32'h10, 0), "wr", 2);
    wr_en = 1'b1; wr_data = 32'hCAFE_F00D;
    run(mk(1, 1, 32'h10, 1, 0, 1, 0, 0,           0,     0), "wr", 3);
    wr_en = 1'b0;
    run(mk(1, 1, 32'h10, 1, 0, 1, 1, 32'hDEAD_BEEF, 32'h10, 0), "wr", 4);
    run(mk(1, 0, 0,     1, 0, 1, 1, 32'hCAFE_F00D, 32'h10, 0), "wr", 5);
    rom_m[4] = 32'hCAFE_F00D;
`endif

    // Randomized traffic; the model is a bounded queue of expected responses.
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      int unsigned sel;
      v.rst = ($urandom_range(0, 49) != 0);
      v.req = ($urandom_range(0, 9) < 7);
      v.rdy = ($urandom_range(0, 9) < 6);
      v.fl  = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 7)       v.pc = {18'd0, 12'($urandom_range(0, ROM_D - 1)), 2'b00};
      else if (sel == 7) v.pc = {18'd0, 12'($urandom), 2'($urandom_range(1, 3))};
      else if (sel == 8) v.pc = 32'h4000 + $urandom_range(0, 32'h7fff_0000);
      else               v.pc = 32'(4 * ROM_D);
      if (!v.rst) begin
        v.e_rdy = 0; v.e_vld = 0; v.e_data = 0; v.e_pc = 0; v.e_err = 0;
      end else begin
        v.e_rdy = (q.size() < RSP_D) && !v.fl;
        v.e_vld = (q.size() != 0);
        if (v.e_vld) begin
          h = q[0];
          v.e_data = h.data; v.e_pc = h.pc; v.e_err = h.err;
        end else begin
          v.e_data = 0; v.e_pc = 0; v.e_err = 0;
        end
      end
      run(v, "rnd", c);
      if (!v.rst || v.fl) q.delete();
      else begin
        if (v.e_vld && v.rdy) void'(q.pop_front());
        if (v.req && v.e_rdy) q.push_back(ref_rsp(v.pc));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
